// File: rtl/spi_slave_if.sv
// Bus bundle between the SPI slave and its surroundings: SPI pins plus the TX/RX byte handshakes.
interface spi_slave_if;
  logic       sclk;
  logic       cs_n;
  logic       mosi;
  logic       miso;
  logic       miso_oe;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ack;
  logic       overrun;
  logic       busy;

  modport slave (
    input  sclk, cs_n, mosi, tx_data, tx_valid, rx_ack,
    output miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );

  modport master (
    output sclk, cs_n, mosi, tx_data, tx_valid, rx_ack,
    input  miso, miso_oe, tx_ready, rx_data, rx_valid, overrun, busy
  );
endinterface

// File: rtl/spi_slave.sv
// Mode-0 SPI slave oversampled in the clk domain, with a one-deep TX buffer and an RX holding register.
// Define SPI_SLAVE_OVERRUN_EN to enable the sticky receive-overrun flag (otherwise overrun is tied 0).
module spi_slave #(
  parameter logic [7:0] IDLE_BYTE   = 8'hFF,
  parameter int         SYNC_STAGES = 2
) (
  input logic        clk,
  input logic        rst,
  spi_slave_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, mosi_sync, fill_sync;
  logic       sclk_d, cs_d, armed;
  logic       sclk_s, cs_s, mosi_s;
  logic       sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic       start, stop, rx_step, tx_step, load, complete, wr;
  logic [7:0] tx_sh, tx_buf, rx_data_q;
  logic [6:0] rx_sh;
  logic [2:0] bit_cnt;
  logic       tx_full, rx_valid_q, reload_pend;

  // Synchronizers plus one edge-detect flop. fill_sync marks when cs_sync holds real samples;
  // armed then requires cs_n to be seen high so a reset mid-transfer waits for a fresh select.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      fill_sync <= '0;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      armed     <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
      fill_sync <= {fill_sync[SYNC_STAGES-2:0], 1'b1};
      sclk_d    <= sclk_s;
      cs_d      <= cs_s;
      if (fill_sync[SYNC_STAGES-1] && cs_s) armed <= 1'b1;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s & sclk_d;
  assign cs_rise   = cs_s & ~cs_d;
  assign cs_fall   = ~cs_s & cs_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    stop    = 1'b0;
    rx_step = 1'b0;
    tx_step = 1'b0;
    case (state_q)
      IDLE: begin
        if (armed && cs_fall) begin
          state_d = ACTIVE;
          start   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_d = IDLE;
          stop    = 1'b1;
        end else begin
          rx_step = sclk_rise;
          tx_step = sclk_fall;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr       = bus.tx_valid & ~tx_full;
  assign load     = start | (tx_step & reload_pend);
  assign complete = rx_step & (bit_cnt == 3'd7);

  // A load takes the buffered byte, else a write landing in the same cycle, else the idle pattern.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_sh       <= '0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      rx_sh       <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      bit_cnt     <= '0;
      reload_pend <= 1'b0;
    end else begin
      if (load) begin
        if (tx_full) begin
          tx_sh   <= tx_buf;
          tx_full <= 1'b0;
        end else if (wr) begin
          tx_sh <= bus.tx_data;
        end else begin
          tx_sh <= IDLE_BYTE;
        end
      end else begin
        if (tx_step) tx_sh <= {tx_sh[6:0], 1'b0};
        if (wr) begin
          tx_buf  <= bus.tx_data;
          tx_full <= 1'b1;
        end
      end

      if (start || stop)  bit_cnt <= '0;
      else if (rx_step)   bit_cnt <= bit_cnt + 3'd1;

      if (rx_step)  rx_sh     <= {rx_sh[5:0], mosi_s};
      if (complete) rx_data_q <= {rx_sh, mosi_s};

      if (complete)         rx_valid_q <= 1'b1;
      else if (bus.rx_ack)  rx_valid_q <= 1'b0;

      // The falling edge after a completed byte reloads the shifter instead of shifting.
      if (start || stop)    reload_pend <= 1'b0;
      else if (complete)    reload_pend <= 1'b1;
      else if (tx_step)     reload_pend <= 1'b0;
    end
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                     overrun_q <= 1'b0;
    else if (complete && rx_valid_q && !bus.rx_ack) overrun_q <= 1'b1;
    else if (bus.rx_ack)                         overrun_q <= 1'b0;
  end

  assign bus.overrun = overrun_q;
`else
  assign bus.overrun = 1'b0;
`endif

  assign bus.busy     = (state_q == ACTIVE);
  assign bus.miso_oe  = (state_q == ACTIVE);
  assign bus.miso     = (state_q == ACTIVE) & tx_sh[7];
  assign bus.tx_ready = ~tx_full;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: a bit-banged mode-0 master against a queue-based byte model.
module tb_spi_slave;
  localparam int         HALF  = 8;
  localparam logic [7:0] IDLEB = 8'hFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  spi_slave_if bus();
  spi_slave #(.IDLE_BYTE(IDLEB), .SYNC_STAGES(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int         checks = 0;
  int         errors = 0;
  logic [7:0] txq[$];
  logic [7:0] mo[8];
  logic [7:0] got[8];
  bit         wr_en[8];
  logic [7:0] wr_val[8];
  bit         auto_ack;
  logic [7:0] last_rx;

  initial begin
    #600000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  function automatic logic [7:0] pop_tx();
    if (txq.size() > 0) return txq.pop_front();
    return IDLEB;
  endfunction

  task automatic clear_plan();
    for (int k = 0; k < 8; k++) begin
      wr_en[k]  = 1'b0;
      wr_val[k] = 8'h00;
      mo[k]     = 8'h00;
    end
  endtask

  task automatic tx_write(input logic [7:0] v);
    int n = 0;
    while (bus.tx_ready !== 1'b1 && n < 50) begin
      tick(1);
      n++;
    end
    checks++;
    if (bus.tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL tx_write_wait got tx_ready=%b exp 1", bus.tx_ready);
    end else begin
      bus.tx_data  = v;
      bus.tx_valid = 1'b1;
      tick(1);
      bus.tx_valid = 1'b0;
      txq.push_back(v);
    end
  endtask

  // Full master transaction: nbits clocked with cs_n low. pt requests a tx write timed to the start load.
  task automatic xfer(input int nbits, input bit pt, input logic [7:0] pt_val);
    logic [7:0] exp_tx, shin;
    int b;
    bit ok;
    shin = 8'h00;
    bus.cs_n = 1'b0;
    if (pt) begin
      tick(2);
      bus.tx_data  = pt_val;
      bus.tx_valid = 1'b1;
      tick(1);
      bus.tx_valid = 1'b0;
      txq.push_back(pt_val);
      checks++;
      if (bus.tx_ready !== 1'b1) begin
        errors++;
        $display("FAIL passthrough_tx_ready got %b exp 1", bus.tx_ready);
      end
    end
    exp_tx = pop_tx();
    tick(HALF);
    checks++;
    if (bus.busy !== 1'b1 || bus.miso_oe !== 1'b1) begin
      errors++;
      $display("FAIL active_flags got busy=%b oe=%b exp 1 1", bus.busy, bus.miso_oe);
    end
    for (int i = 0; i < nbits; i++) begin
      b = i / 8;
      bus.mosi = mo[b][7 - (i % 8)];
      tick(HALF);
      if ((i % 8) == 0 && wr_en[b]) tx_write(wr_val[b]);
      shin = {shin[6:0], bus.miso};
      bus.sclk = 1'b1;
      if ((i % 8) == 7) begin
        got[b] = shin;
        checks++;
        if (shin !== exp_tx) begin
          errors++;
          $display("FAIL miso_byte %0d got %h exp %h", b, shin, exp_tx);
        end
        ok = 1'b0;
        for (int k = 0; k < 3 && !ok; k++) begin
          tick(1);
          if (bus.rx_valid === 1'b1) ok = 1'b1;
        end
        checks++;
        if (!ok) begin
          errors++;
          $display("FAIL rx_valid_latency byte %0d got 0 exp 1 within 3 clk", b);
        end
        last_rx = mo[b];
        exp_tx  = pop_tx();
      end
      tick(HALF);
      if ((i % 8) == 7 && auto_ack) begin
        checks++;
        if (bus.rx_data !== mo[b]) begin
          errors++;
          $display("FAIL rx_data byte %0d got %h exp %h", b, bus.rx_data, mo[b]);
        end
        bus.rx_ack = 1'b1;
        tick(1);
        bus.rx_ack = 1'b0;
        checks++;
        if (bus.rx_valid !== 1'b0) begin
          errors++;
          $display("FAIL rx_valid_after_ack got %b exp 0", bus.rx_valid);
        end
      end
      bus.sclk = 1'b0;
    end
    tick(HALF);
    bus.cs_n = 1'b1;
    tick(HALF);
  endtask

  task automatic toggle_bits(input logic [7:0] v, input int n);
    for (int k = 0; k < n; k++) begin
      bus.mosi = v[7 - k];
      tick(HALF);
      bus.sclk = 1'b1;
      tick(HALF);
      bus.sclk = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (bus.miso !== 1'b0)      begin errors++; $display("FAIL rst_miso got %b exp 0", bus.miso); end
    checks++; if (bus.miso_oe !== 1'b0)   begin errors++; $display("FAIL rst_miso_oe got %b exp 0", bus.miso_oe); end
    checks++; if (bus.tx_ready !== 1'b1)  begin errors++; $display("FAIL rst_tx_ready got %b exp 1", bus.tx_ready); end
    checks++; if (bus.rx_data !== 8'h00)  begin errors++; $display("FAIL rst_rx_data got %h exp 00", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b0)  begin errors++; $display("FAIL rst_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.overrun !== 1'b0)   begin errors++; $display("FAIL rst_overrun got %b exp 0", bus.overrun); end
    checks++; if (bus.busy !== 1'b0)      begin errors++; $display("FAIL rst_busy got %b exp 0", bus.busy); end
    rst = 1'b0;
    txq.delete();
    last_rx = 8'h00;
    tick(HALF);
  endtask

  task automatic test_basic();
    clear_plan();
    auto_ack = 1'b0;
    tx_write(8'hA5);
    mo[0] = 8'h3C;
    xfer(8, 1'b0, 8'h00);
    checks++; if (got[0] !== 8'hA5)       begin errors++; $display("FAIL basic_miso got %h exp a5", got[0]); end
    checks++; if (bus.rx_data !== 8'h3C)  begin errors++; $display("FAIL basic_rx_data got %h exp 3c", bus.rx_data); end
    checks++; if (bus.rx_valid !== 1'b1)  begin errors++; $display("FAIL basic_rx_valid got %b exp 1", bus.rx_valid); end
    bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
    checks++; if (bus.rx_valid !== 1'b0)  begin errors++; $display("FAIL basic_ack got %b exp 0", bus.rx_valid); end
    bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
    tick(1);
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.rx_data !== 8'h3C) begin
      errors++;
      $display("FAIL stray_ack got valid=%b data=%h exp 0 3c", bus.rx_valid, bus.rx_data);
    end
    checks++; if (bus.miso !== 1'b0 || bus.miso_oe !== 1'b0) begin errors++; $display("FAIL idle_miso got %b/%b exp 0/0", bus.miso, bus.miso_oe); end
  endtask

  task automatic test_idle_byte();
    clear_plan();
    auto_ack = 1'b1;
    mo[0] = 8'h00;
    xfer(8, 1'b0, 8'h00);
    checks++; if (got[0] !== 8'hFF)      begin errors++; $display("FAIL idle_byte got %h exp ff", got[0]); end
    checks++; if (bus.tx_ready !== 1'b1) begin errors++; $display("FAIL idle_tx_ready got %b exp 1", bus.tx_ready); end
  endtask

  task automatic test_back_to_back();
    clear_plan();
    auto_ack = 1'b1;
    tx_write(8'h55);
    wr_en[0] = 1'b1; wr_val[0] = 8'hAA;
    mo[0] = 8'h11; mo[1] = 8'h22;
    xfer(16, 1'b0, 8'h00);
    checks++; if (got[0] !== 8'h55) begin errors++; $display("FAIL b2b_miso0 got %h exp 55", got[0]); end
    checks++; if (got[1] !== 8'hAA) begin errors++; $display("FAIL b2b_miso1 got %h exp aa", got[1]); end
  endtask

  task automatic test_abort();
    logic [7:0] keep;
    clear_plan();
    auto_ack = 1'b1;
    keep = last_rx;
    mo[0] = 8'($urandom);
    wr_en[0] = 1'b1; wr_val[0] = 8'($urandom);
    xfer(5, 1'b0, 8'h00);
    tick(4);
    checks++; if (bus.rx_valid !== 1'b0) begin errors++; $display("FAIL abort_rx_valid got %b exp 0", bus.rx_valid); end
    checks++; if (bus.rx_data !== keep)  begin errors++; $display("FAIL abort_rx_data got %h exp %h", bus.rx_data, keep); end
    checks++; if (bus.tx_ready !== 1'b0) begin errors++; $display("FAIL abort_tx_kept got tx_ready=%b exp 0", bus.tx_ready); end
    clear_plan();
    mo[0] = 8'h7E;
    xfer(8, 1'b0, 8'h00);
    checks++; if (bus.rx_data !== 8'h7E) begin errors++; $display("FAIL after_abort got %h exp 7e", bus.rx_data); end
  endtask

  task automatic test_passthrough();
    logic [7:0] v;
    clear_plan();
    auto_ack = 1'b1;
    v = 8'($urandom);
    mo[0] = 8'($urandom);
    xfer(8, 1'b1, v);
    checks++; if (got[0] !== v) begin errors++; $display("FAIL passthrough_miso got %h exp %h", got[0], v); end
  endtask

  task automatic test_random();
    int nb;
    for (int t = 0; t < 6; t++) begin
      clear_plan();
      auto_ack = 1'b1;
      nb = $urandom_range(1, 3);
      if ($urandom_range(0, 1) == 1) tx_write(8'($urandom));
      for (int k = 0; k < nb; k++) begin
        mo[k]     = 8'($urandom);
        wr_en[k]  = ($urandom_range(0, 1) == 1);
        wr_val[k] = 8'($urandom);
      end
      xfer(nb * 8, 1'b0, 8'h00);
    end
  endtask

  task automatic test_overrun();
    logic exp_ovr;
`ifdef SPI_SLAVE_OVERRUN_EN
    exp_ovr = 1'b1;
`else
    exp_ovr = 1'b0;
`endif
    clear_plan();
    auto_ack = 1'b0;
    mo[0] = 8'($urandom);
    mo[1] = 8'($urandom);
    xfer(16, 1'b0, 8'h00);
    checks++; if (bus.overrun !== exp_ovr) begin errors++; $display("FAIL overrun_set got %b exp %b", bus.overrun, exp_ovr); end
    checks++; if (bus.rx_data !== mo[1])   begin errors++; $display("FAIL overrun_data got %h exp %h", bus.rx_data, mo[1]); end
    checks++; if (bus.rx_valid !== 1'b1)   begin errors++; $display("FAIL overrun_valid got %b exp 1", bus.rx_valid); end
    bus.rx_ack = 1'b1; tick(1); bus.rx_ack = 1'b0;
    checks++;
    if (bus.overrun !== 1'b0 || bus.rx_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_clear got ovr=%b valid=%b exp 0 0", bus.overrun, bus.rx_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] obs;
    clear_plan();
    tx_write(8'($urandom));
    bus.cs_n = 1'b0;
    tick(HALF);
    tx_write(8'($urandom));
    toggle_bits(8'($urandom), 4);
    rst = 1'b1;
    #1;
    obs = {bus.miso, bus.miso_oe, bus.tx_ready, bus.rx_data, bus.rx_valid, bus.overrun, bus.busy};
    checks++;
    if (obs !== 14'b0_0_1_00000000_0_0_0) begin
      errors++;
      $display("FAIL reset_mid_outputs got %b exp 00100000000000", obs);
    end
    tick(2);
    rst = 1'b0;
    txq.delete();
    last_rx = 8'h00;
    toggle_bits(8'($urandom), 8);
    tick(4);
    checks++;
    if (bus.rx_valid !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ignored got valid=%b busy=%b exp 0 0", bus.rx_valid, bus.busy);
    end
    bus.cs_n = 1'b1;
    tick(HALF);
    auto_ack = 1'b1;
    mo[0] = 8'($urandom);
    xfer(8, 1'b0, 8'h00);
    checks++; if (bus.rx_data !== mo[0]) begin errors++; $display("FAIL reset_mid_resume got %h exp %h", bus.rx_data, mo[0]); end
  endtask

  initial begin
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    bus.rx_ack   = 1'b0;
    auto_ack     = 1'b0;
    last_rx      = 8'h00;
    test_reset();
    test_basic();
    test_idle_byte();
    test_back_to_back();
    test_abort();
    test_passthrough();
    test_random();
    test_overrun();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
